// File: rtl/sp_pkg.sv
// Shared definitions for the serial_paralelo converter: FSM state encoding
// and default link parameters.
package sp_pkg;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    SYNC   = 2'd1,
    ACTIVE = 2'd2
  } sp_state_t;

  localparam int unsigned SP_WIDTH_DEF      = 8;
  localparam logic [7:0]  SP_COM_DEF        = 8'hBC;
  localparam int unsigned SP_SYNC_COUNT_DEF = 4;

endpackage

// File: rtl/serial_paralelo_if.sv
// Handshake bundle between the serial source, the converter and the parallel
// datapath. Optional toggle_count present only with SP_TOGGLE_COUNT_EN.
interface serial_paralelo_if #(
  parameter int unsigned WIDTH = 8
) ();

  logic             data_in;
  logic             valid_in;
  logic [WIDTH-1:0] data_out;
  logic             valid_out;
  logic             active;
`ifdef SP_TOGGLE_COUNT_EN
  logic [15:0]      toggle_count;

  modport master (
    output data_in, valid_in,
    input  data_out, valid_out, active, toggle_count
  );

  modport slave (
    input  data_in, valid_in,
    output data_out, valid_out, active, toggle_count
  );
`else
  modport master (
    output data_in, valid_in,
    input  data_out, valid_out, active
  );

  modport slave (
    input  data_in, valid_in,
    output data_out, valid_out, active
  );
`endif

endinterface

// File: rtl/serial_paralelo_shift.sv
// Serial shift register with byte-position counter. o_window is the value the
// register will hold after the current bit is shifted in; o_byte_done flags
// the bit that completes a byte. i_align restarts byte framing.
module serial_paralelo_shift #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_valid,
  input  logic             i_bit,
  input  logic             i_align,
  output logic [WIDTH-1:0] o_window,
  output logic             o_byte_done
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [WIDTH-1:0] r_shift;
  logic [CW-1:0]    r_bit_cnt;
  logic             w_last_bit;

  assign w_last_bit  = (r_bit_cnt == CW'(WIDTH - 1));
  assign o_window    = {r_shift[WIDTH-2:0], i_bit};
  assign o_byte_done = i_valid && !i_align && w_last_bit;

  // Shift one bit per qualified cycle and track position within the byte.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shift   <= '0;
      r_bit_cnt <= '0;
    end else if (i_valid) begin
      r_shift <= o_window;
      if (i_align || w_last_bit) begin
        r_bit_cnt <= '0;
      end else begin
        r_bit_cnt <= r_bit_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/serial_paralelo.sv
// Serial-to-parallel converter: locks on COM, needs SYNC_COUNT consecutive
// COM bytes to go ACTIVE, then strobes out every non-COM byte.
// Optional feature macro: SP_TOGGLE_COUNT_EN (adds toggle_count output).
module serial_paralelo
  import sp_pkg::*;
#(
  parameter int unsigned      WIDTH      = SP_WIDTH_DEF,
  parameter logic [WIDTH-1:0] COM        = WIDTH'(SP_COM_DEF),
  parameter int unsigned      SYNC_COUNT = SP_SYNC_COUNT_DEF
) (
  input logic              clk,
  input logic              rst,
  serial_paralelo_if.slave sp
);

  localparam int unsigned CCW = $clog2(SYNC_COUNT + 1);

  sp_state_t        r_state;
  logic [CCW-1:0]   r_com_cnt;
  logic [WIDTH-1:0] r_data_out;
  logic             r_valid_out;
  logic             r_active;

  logic [WIDTH-1:0] w_window;
  logic             w_byte_done;
  logic             w_align;
  logic             w_is_com;
  logic             w_emit;

  assign w_is_com = (w_window == COM);
  assign w_align  = (r_state == SEARCH) && sp.valid_in && w_is_com;
  assign w_emit   = (r_state == ACTIVE) && w_byte_done && !w_is_com;

  serial_paralelo_shift #(
    .WIDTH (WIDTH)
  ) u_shift (
    .clk         (clk),
    .rst         (rst),
    .i_valid     (sp.valid_in),
    .i_bit       (sp.data_in),
    .i_align     (w_align),
    .o_window    (w_window),
    .o_byte_done (w_byte_done)
  );

  // Link FSM with registered data/strobe/active outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= SEARCH;
      r_com_cnt   <= '0;
      r_data_out  <= '0;
      r_valid_out <= 1'b0;
      r_active    <= 1'b0;
    end else begin
      r_valid_out <= 1'b0;
      if (sp.valid_in) begin
        case (r_state)
          SEARCH: begin
            if (w_is_com) begin
              r_com_cnt <= CCW'(1);
              if (SYNC_COUNT <= 1) begin
                r_state  <= ACTIVE;
                r_active <= 1'b1;
              end else begin
                r_state <= SYNC;
              end
            end
          end
          SYNC: begin
            if (w_byte_done) begin
              if (w_is_com) begin
                if (r_com_cnt >= CCW'(SYNC_COUNT - 1)) begin
                  r_com_cnt <= CCW'(SYNC_COUNT);
                  r_state   <= ACTIVE;
                  r_active  <= 1'b1;
                end else begin
                  r_com_cnt <= r_com_cnt + 1'b1;
                end
              end else begin
                r_com_cnt <= '0;
                r_state   <= SEARCH;
              end
            end
          end
          ACTIVE: begin
            if (w_emit) begin
              r_data_out  <= w_window;
              r_valid_out <= 1'b1;
            end
          end
          default: begin
            r_state <= SEARCH;
          end
        endcase
      end
    end
  end

  assign sp.data_out  = r_data_out;
  assign sp.valid_out = r_valid_out;
  assign sp.active    = r_active;

`ifdef SP_TOGGLE_COUNT_EN
  localparam int unsigned TW = $clog2(WIDTH + 1);

  logic [15:0]   r_toggle_count;
  logic [TW-1:0] w_toggles;
  logic [16:0]   w_toggle_sum;

  // Number of data_out bits that flip when the new byte is loaded.
  always_comb begin
    w_toggles = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      w_toggles = w_toggles + TW'(r_data_out[i] ^ w_window[i]);
    end
  end

  assign w_toggle_sum = {1'b0, r_toggle_count} + 17'(w_toggles);

  // Saturating accumulation of output switching activity.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_toggle_count <= '0;
    end else if (sp.valid_in && w_emit) begin
      r_toggle_count <= w_toggle_sum[16] ? 16'hFFFF : w_toggle_sum[15:0];
    end
  end

  assign sp.toggle_count = r_toggle_count;
`endif

endmodule

// File: tb/tb_serial_paralelo.sv
// Directed bench for serial_paralelo: reset, lock, failed sync, idle COM in
// ACTIVE, valid_in gaps and (with SP_TOGGLE_COUNT_EN) toggle counting.
module tb_serial_paralelo;
  import sp_pkg::*;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  serial_paralelo_if #(.WIDTH(8)) sp_if ();

  serial_paralelo #(
    .WIDTH      (8),
    .COM        (8'hBC),
    .SYNC_COUNT (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .sp  (sp_if)
  );

  int n_vec = 0;
  int n_err = 0;
  int strobes = 0;
  logic [7:0] log_q[$];

  // Strobe monitor: outputs are registered, so sample on the falling edge.
  always @(negedge clk) begin
    if (sp_if.valid_out === 1'b1) begin
      strobes++;
      log_q.push_back(sp_if.data_out);
    end
  end

  task automatic send_bit(input logic b);
    @(negedge clk);
    sp_if.data_in  = b;
    sp_if.valid_in = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) send_bit(v[i]);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      sp_if.valid_in = 1'b0;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic lock_link();
    for (int i = 0; i < 4; i++) send_byte(8'hBC);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst            = 1'b1;
    sp_if.valid_in = 1'b0;
    sp_if.data_in  = 1'b0;
    @(posedge clk);
    #1;
    @(negedge clk);
    rst = 1'b0;
    strobes = 0;
    log_q.delete();
  endtask

  task automatic test_reset();
    do_reset();
    n_vec++;
    if (sp_if.data_out !== 8'h00) begin
      n_err++; $display("FAIL reset_data_out: got %h expected 00", sp_if.data_out);
    end
    n_vec++;
    if (sp_if.valid_out !== 1'b0) begin
      n_err++; $display("FAIL reset_valid_out: got %b expected 0", sp_if.valid_out);
    end
    n_vec++;
    if (sp_if.active !== 1'b0) begin
      n_err++; $display("FAIL reset_active: got %b expected 0", sp_if.active);
    end
    lock_link();
    send_byte(8'h5A);
    n_vec++;
    if (sp_if.data_out !== 8'h5A) begin
      n_err++; $display("FAIL premid_data_out: got %h expected 5a", sp_if.data_out);
    end
    // five bits of 0x96 then asynchronous reset mid-cycle
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
    #2 rst = 1'b1;
    #1;
    n_vec++;
    if (sp_if.data_out !== 8'h00) begin
      n_err++; $display("FAIL midrst_data_out: got %h expected 00", sp_if.data_out);
    end
    n_vec++;
    if (sp_if.valid_out !== 1'b0) begin
      n_err++; $display("FAIL midrst_valid_out: got %b expected 0", sp_if.valid_out);
    end
    n_vec++;
    if (sp_if.active !== 1'b0) begin
      n_err++; $display("FAIL midrst_active: got %b expected 0", sp_if.active);
    end
    @(negedge clk);
    rst = 1'b0;
    strobes = 0;
    send_bit(1'b1); send_bit(1'b1); send_bit(1'b0);
    idle(3);
    n_vec++;
    if (strobes !== 0) begin
      n_err++; $display("FAIL midrst_no_strobe: got %0d strobes expected 0", strobes);
    end
    n_vec++;
    if (sp_if.active !== 1'b0) begin
      n_err++; $display("FAIL midrst_active_after: got %b expected 0", sp_if.active);
    end
  endtask

  task automatic test_lock();
    do_reset();
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    for (int i = 0; i < 3; i++) send_byte(8'hBC);
    n_vec++;
    if (sp_if.active !== 1'b0) begin
      n_err++; $display("FAIL lock_active_3com: got %b expected 0", sp_if.active);
    end
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
    send_bit(1'b1); send_bit(1'b1); send_bit(1'b0);
    n_vec++;
    if (sp_if.active !== 1'b0) begin
      n_err++; $display("FAIL lock_active_7bits: got %b expected 0", sp_if.active);
    end
    send_bit(1'b0);
    n_vec++;
    if (sp_if.active !== 1'b1) begin
      n_err++; $display("FAIL lock_active_4com: got %b expected 1", sp_if.active);
    end
    send_byte(8'h5A);
    n_vec++;
    if (sp_if.valid_out !== 1'b1 || sp_if.data_out !== 8'h5A) begin
      n_err++; $display("FAIL lock_strobe: got v=%b d=%h expected v=1 d=5a",
                        sp_if.valid_out, sp_if.data_out);
    end
    send_bit(1'b0);
    n_vec++;
    if (sp_if.valid_out !== 1'b0) begin
      n_err++; $display("FAIL lock_strobe_width: got %b expected 0", sp_if.valid_out);
    end
    idle(2);
    n_vec++;
    if (strobes !== 1) begin
      n_err++; $display("FAIL lock_strobe_count: got %0d expected 1", strobes);
    end
  endtask

  task automatic test_failed_sync();
    do_reset();
    send_byte(8'hBC); send_byte(8'hBC); send_byte(8'h11);
    for (int i = 0; i < 3; i++) send_byte(8'hBC);
    n_vec++;
    if (sp_if.active !== 1'b0) begin
      n_err++; $display("FAIL fsync_active_early: got %b expected 0", sp_if.active);
    end
    send_byte(8'hBC);
    n_vec++;
    if (sp_if.active !== 1'b1) begin
      n_err++; $display("FAIL fsync_active: got %b expected 1", sp_if.active);
    end
    send_byte(8'h22);
    n_vec++;
    if (sp_if.valid_out !== 1'b1 || sp_if.data_out !== 8'h22) begin
      n_err++; $display("FAIL fsync_strobe: got v=%b d=%h expected v=1 d=22",
                        sp_if.valid_out, sp_if.data_out);
    end
    idle(2);
    n_vec++;
    if (strobes !== 1 || log_q.size() < 1 || log_q[0] !== 8'h22) begin
      n_err++; $display("FAIL fsync_log: got %0d strobes expected 1 strobe of 22", strobes);
    end
  endtask

  task automatic test_idle_com();
    do_reset();
    lock_link();
    send_byte(8'hA1);
    n_vec++;
    if (sp_if.valid_out !== 1'b1 || sp_if.data_out !== 8'hA1) begin
      n_err++; $display("FAIL idle_a1: got v=%b d=%h expected v=1 d=a1",
                        sp_if.valid_out, sp_if.data_out);
    end
    for (int k = 0; k < 2; k++) begin
      send_byte(8'hBC);
      n_vec++;
      if (sp_if.valid_out !== 1'b0 || sp_if.data_out !== 8'hA1) begin
        n_err++; $display("FAIL idle_com%0d: got v=%b d=%h expected v=0 d=a1",
                          k, sp_if.valid_out, sp_if.data_out);
      end
    end
    send_byte(8'hA2);
    n_vec++;
    if (sp_if.valid_out !== 1'b1 || sp_if.data_out !== 8'hA2) begin
      n_err++; $display("FAIL idle_a2: got v=%b d=%h expected v=1 d=a2",
                        sp_if.valid_out, sp_if.data_out);
    end
    idle(2);
    n_vec++;
    if (strobes !== 2 || log_q.size() != 2 || log_q[0] !== 8'hA1 || log_q[1] !== 8'hA2) begin
      n_err++; $display("FAIL idle_log: got %0d strobes expected 2 (a1,a2)", strobes);
    end
  endtask

  task automatic test_gaps();
    do_reset();
    lock_link();
    send_bit(1'b0); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
    for (int k = 0; k < 3; k++) begin
      idle(1);
      n_vec++;
      if (sp_if.valid_out !== 1'b0 || sp_if.active !== 1'b1) begin
        n_err++; $display("FAIL gap_cycle%0d: got v=%b a=%b expected v=0 a=1",
                          k, sp_if.valid_out, sp_if.active);
      end
    end
    send_bit(1'b1); send_bit(1'b1); send_bit(1'b0);
    n_vec++;
    if (sp_if.valid_out !== 1'b0) begin
      n_err++; $display("FAIL gap_early: got %b expected 0", sp_if.valid_out);
    end
    send_bit(1'b0);
    n_vec++;
    if (sp_if.valid_out !== 1'b1 || sp_if.data_out !== 8'h3C) begin
      n_err++; $display("FAIL gap_3c: got v=%b d=%h expected v=1 d=3c",
                        sp_if.valid_out, sp_if.data_out);
    end
    send_byte(8'hC3);
    n_vec++;
    if (sp_if.valid_out !== 1'b1 || sp_if.data_out !== 8'hC3) begin
      n_err++; $display("FAIL gap_c3: got v=%b d=%h expected v=1 d=c3",
                        sp_if.valid_out, sp_if.data_out);
    end
    idle(2);
    n_vec++;
    if (strobes !== 2) begin
      n_err++; $display("FAIL gap_strobe_count: got %0d expected 2", strobes);
    end
  endtask

`ifdef SP_TOGGLE_COUNT_EN
  task automatic test_toggle_count();
    logic [15:0] exp_tc[3];
    logic [7:0]  bytes[3];
    exp_tc = '{16'd0, 16'd8, 16'd12};
    bytes  = '{8'h00, 8'hFF, 8'h0F};
    do_reset();
    n_vec++;
    if (sp_if.toggle_count !== 16'd0) begin
      n_err++; $display("FAIL toggle_reset: got %0d expected 0", sp_if.toggle_count);
    end
    lock_link();
    for (int k = 0; k < 3; k++) begin
      send_byte(bytes[k]);
      n_vec++;
      if (sp_if.toggle_count !== exp_tc[k]) begin
        n_err++; $display("FAIL toggle_%0d: got %0d expected %0d",
                          k, sp_if.toggle_count, exp_tc[k]);
      end
    end
  endtask
`endif

  initial begin
    rst            = 1'b1;
    sp_if.data_in  = 1'b0;
    sp_if.valid_in = 1'b0;
    test_reset();
    test_lock();
    test_failed_sync();
    test_idle_com();
    test_gaps();
`ifdef SP_TOGGLE_COUNT_EN
    test_toggle_count();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
